// File: rtl/lsu_unit_pkg.sv
// lsu_unit_pkg: funct3 encodings, LSU states and access-decode helpers shared by the LSU
package lsu_unit_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_e;
  function automatic logic legal(input logic we, input logic [2:0] f3);
    return we ? (f3 == F3_B || f3 == F3_H || f3 == F3_W) : (f3 != 3'b011 && f3[2:1] != 2'b11);
  endfunction
  function automatic logic aligned(input logic [1:0] sz, input logic [1:0] off);
    return sz[0] ? !off[0] : sz[1] ? off == 2'b00 : 1'b1;
  endfunction
  function automatic logic [3:0] strb(input logic [1:0] sz, input logic [1:0] off);
    return sz[1] ? 4'b1111 : sz[0] ? 4'b0011 << off : 4'b0001 << off;
  endfunction
  function automatic logic [31:0] lanes(input logic [1:0] sz, input logic [31:0] d);
    return sz[1] ? d : sz[0] ? {2{d[15:0]}} : {4{d[7:0]}};
  endfunction
endpackage

// File: rtl/lsu_load_extend.sv
// lsu_load_extend: selects the addressed lane of a read word and sign/zero-extends it
module lsu_load_extend
  import lsu_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  logic [31:0] sh;
  always_comb begin
    sh = rdata >> {offset, 3'b000};
    data = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
           funct3 == F3_BU ? {24'b0, sh[7:0]} :
           funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
           funct3 == F3_HU ? {16'b0, sh[15:0]} : sh;
  end
endmodule

// File: rtl/lsu_unit.sv
// lsu_unit: load/store unit running one req/ack memory transaction per access, stalling the core meanwhile
module lsu_unit
  import lsu_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] load_data,
  output logic              done,
  output logic              fault,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);
  lsu_state_e state, state_nx;
  logic start, bad;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic [DATA_W-1:0] ext;
  lsu_load_extend u_ext (.rdata(mem_rdata), .offset(off_q), .funct3(f3_q), .data(ext));
  always_comb begin
    start = (mem_read | mem_write) & legal(mem_write, funct3) & aligned(funct3[1:0], addr[1:0]);
    bad = (mem_read | mem_write) & !start;
  end
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
  always_comb begin
    state_nx = state == IDLE ? (start ? REQ : IDLE) :
               state == REQ  ? (mem_ack ? DONE : REQ) : IDLE;
  end
  always_comb begin
    mem_req = state == REQ;
    done = state == DONE;
    stall = (state == IDLE && start) || state == REQ;
  end
  // request fields are captured once in IDLE so the core may change its inputs during REQ
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_data <= '0;
      fault <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
      f3_q <= '0;
      off_q <= '0;
    end else begin
      fault <= state == IDLE && bad;
      if (state == IDLE && start) begin
        mem_we <= mem_write;
        f3_q <= funct3;
        off_q <= addr[1:0];
        mem_addr <= {addr[ADDR_W-1:2], 2'b00};
        mem_wstrb <= mem_write ? strb(funct3[1:0], addr[1:0]) : 4'b0000;
        mem_wdata <= mem_write ? lanes(funct3[1:0], store_data) : '0;
      end
      if (state == REQ && mem_ack && !mem_we) load_data <= ext;
    end
  end
endmodule

// File: tb/tb_lsu_unit.sv
// tb_lsu_unit: directed table plus randomized accesses checked against a spec-level LSU model
module tb_lsu_unit;
  logic clk = 0, rst_n = 0, mem_read = 0, mem_write = 0, mem_ack = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] addr = 0, store_data = 0, mem_rdata = 0;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0] mem_wstrb;
  logic done, fault, stall, mem_req, mem_we;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] model_ld;

  typedef struct {
    logic rd, wr;
    logic [2:0] f3;
    logic [31:0] addr, sd, rdata;
    int delay;
    logic garbage, exp_fault;
    logic [31:0] exp_ld;
    logic [3:0] exp_strb;
    logic [31:0] exp_wdata, exp_maddr;
  } vec_t;

  lsu_unit dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .store_data(store_data), .load_data(load_data), .done(done), .fault(fault),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction
  function automatic bit m_legal(input logic wr, input logic [2:0] f3);
    return wr ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
  endfunction
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int nb = nbytes(f3);
    longint span = longint'(1) << (8 * nb);
    longint v = (longint'(rd) >> (8 * (a % 4))) % span;
    if (!f3[2] && nb < 4 && v >= span / 2) v -= span;
    return v[31:0];
  endfunction

  task automatic run_vec(input string tag, input vec_t v);
    int stalls = 0, reqc = 0, dones = 0, faults = 0, done_c = -1, unstable = 0;
    logic [31:0] ma = 0, md = 0;
    logic mw = 0;
    logic [3:0] ms = 0;
    mem_read = v.rd; mem_write = v.wr; funct3 = v.f3; addr = v.addr; store_data = v.sd;
    for (int c = 0; c < v.delay + 4; c++) begin
      if (c > 0) begin
        mem_read = 0; mem_write = 0;
        if (v.garbage) begin addr = $urandom; store_data = $urandom; end
      end
      mem_ack = 0;
      mem_rdata = $urandom;
      #1;
      if (mem_req) begin
        reqc++;
        if (reqc == 1) begin ma = mem_addr; mw = mem_we; ms = mem_wstrb; md = mem_wdata; end
        else if (ma !== mem_addr || mw !== mem_we || ms !== mem_wstrb || md !== mem_wdata) unstable++;
        mem_ack = reqc == v.delay;
        if (mem_ack) mem_rdata = v.rdata;
      end
      #1;
      stalls += int'(stall);
      faults += int'(fault);
      if (done) begin dones++; done_c = c; end
      @(posedge clk); #1;
    end
    mem_ack = 0;
    if (v.exp_fault) begin
      check({tag, " fault pulses"}, faults, 1);
      check({tag, " done pulses"}, dones, 0);
      check({tag, " req cycles"}, reqc, 0);
      check({tag, " stall cycles"}, stalls, 0);
    end else begin
      check({tag, " fault pulses"}, faults, 0);
      check({tag, " done pulses"}, dones, 1);
      check({tag, " done cycle"}, done_c, v.delay + 1);
      check({tag, " stall cycles"}, stalls, v.delay + 1);
      check({tag, " req cycles"}, reqc, v.delay);
      check({tag, " mem_addr"}, ma, v.exp_maddr);
      check({tag, " mem_we"}, mw, v.wr);
      check({tag, " mem stable"}, unstable, 0);
      if (v.wr) begin
        check({tag, " wstrb"}, ms, v.exp_strb);
        check({tag, " wdata"}, md, v.exp_wdata);
      end
    end
    check({tag, " load_data"}, load_data, v.exp_ld);
  endtask

  initial begin
    vec_t tbl[10];
    vec_t v;
    tbl[0] = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, 1'b0, 1'b0, 32'hDEADBEEF, 4'h0, 32'h0, 32'h100};
    tbl[1] = '{1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF1234, 1, 1'b0, 1'b0, 32'hFFFFFF80, 4'h0, 32'h0, 32'h200};
    tbl[2] = '{1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF1234, 1, 1'b0, 1'b0, 32'h00000080, 4'h0, 32'h0, 32'h200};
    tbl[3] = '{1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 32'h80FF1234, 2, 1'b0, 1'b0, 32'hFFFF80FF, 4'h0, 32'h0, 32'h200};
    tbl[4] = '{1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 32'h80FF1234, 3, 1'b0, 1'b0, 32'h000080FF, 4'h0, 32'h0, 32'h200};
    tbl[5] = '{1'b0, 1'b1, 3'b001, 32'h102, 32'h1234BEEF, 32'hCAFEF00D, 1, 1'b0, 1'b0, 32'h000080FF, 4'b1100, 32'hBEEFBEEF, 32'h100};
    tbl[6] = '{1'b1, 1'b0, 3'b010, 32'h1001, 32'h0, 32'h0, 1, 1'b0, 1'b1, 32'h000080FF, 4'h0, 32'h0, 32'h0};
    tbl[7] = '{1'b0, 1'b1, 3'b001, 32'h3, 32'h55, 32'h0, 1, 1'b0, 1'b1, 32'h000080FF, 4'h0, 32'h0, 32'h0};
    tbl[8] = '{1'b1, 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1, 1'b0, 1'b1, 32'h000080FF, 4'h0, 32'h0, 32'h0};
    tbl[9] = '{1'b1, 1'b1, 3'b010, 32'h40, 32'h11223344, 32'h99999999, 5, 1'b1, 1'b0, 32'h000080FF, 4'b1111, 32'h11223344, 32'h40};
    repeat (2) @(posedge clk);
    #1;
    check("reset load_data", load_data, 0);
    check("reset done", done, 0);
    check("reset fault", fault, 0);
    check("reset stall", stall, 0);
    check("reset mem_req", mem_req, 0);
    check("reset mem_we", mem_we, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset mem_wstrb", mem_wstrb, 0);
    check("reset mem_wdata", mem_wdata, 0);
    rst_n = 1;
    @(posedge clk); #1;
    foreach (tbl[i]) run_vec($sformatf("row%0d", i), tbl[i]);
    model_ld = tbl[9].exp_ld;
    for (int i = 0; i < 150; i++) begin
      v.rd = 1'($urandom); v.wr = 1'($urandom);
      if (!v.rd && !v.wr) v.rd = 1;
      v.f3 = 3'($urandom_range(0, 7));
      v.addr = $urandom;
      if ($urandom_range(0, 1) == 1) v.addr = v.addr - v.addr % nbytes(v.f3);
      v.sd = $urandom; v.rdata = $urandom;
      v.delay = $urandom_range(1, 4);
      v.garbage = 1;
      v.exp_fault = !(m_legal(v.wr, v.f3) && v.addr % nbytes(v.f3) == 0);
      if (!v.exp_fault && !v.wr) model_ld = m_load(v.f3, v.addr, v.rdata);
      v.exp_ld = model_ld;
      v.exp_strb = 4'(((1 << nbytes(v.f3)) - 1) << (v.addr % 4));
      v.exp_wdata = nbytes(v.f3) == 1 ? v.sd[7:0] * 32'h01010101 :
                    nbytes(v.f3) == 2 ? v.sd[15:0] * 32'h00010001 : v.sd;
      v.exp_maddr = v.addr - v.addr % 4;
      run_vec($sformatf("rand%0d", i), v);
    end
    // abort a load mid-REQ, then offer a stale ack that must be ignored
    mem_read = 1; funct3 = 3'b010; addr = 32'h300;
    @(posedge clk); #1;
    mem_read = 0;
    check("abort in req", mem_req, 1);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    check("abort mem_req", mem_req, 0);
    check("abort stall", stall, 0);
    check("abort mem_addr", mem_addr, 0);
    check("abort mem_we", mem_we, 0);
    check("abort mem_wstrb", mem_wstrb, 0);
    check("abort mem_wdata", mem_wdata, 0);
    check("abort load_data", load_data, 0);
    mem_ack = 1; mem_rdata = 32'hBAD0BAD0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("stale ack done c%0d", c), done, 0);
      check($sformatf("stale ack req c%0d", c), mem_req, 0);
      check($sformatf("stale ack ld c%0d", c), load_data, 0);
    end
    mem_ack = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
- Load/store unit directly downstream of the ALU.
- Consumes the ALU result as the effective byte address plus the rs2 store value.
- Runs a req/ack transaction against data memory, stalling the core until it completes.
- Returns aligned, sign/zero-extended load data to writeback; flags misaligned or illegal accesses without touching memory.

Parameters:
- ADDR_W, 32, address width of the ALU result and memory address.
- DATA_W, 32, data width (fixed 32; other values unsupported).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- mem_read  in  1  current instruction is a load
- mem_write  in  1  current instruction is a store
- funct3  in  3  access size/sign field of the instruction
- addr  in  ADDR_W  effective byte address (ALU finalValue)
- store_data  in  DATA_W  rs2 value
- load_data  out  DATA_W  extended load result, valid when done=1
- done  out  1  one-cycle pulse: access complete
- fault  out  1  one-cycle pulse: misaligned/illegal access
- stall  out  1  core must hold PC and inputs
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word-aligned address (addr[1:0] forced 0)
- mem_wstrb  out  4  byte write enables
- mem_wdata  out  DATA_W  lane-replicated store data
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  memory completion

Behaviour:
- Reset (sync, rst_n=0 at an edge):
  - state=IDLE.
  - load_data, done, fault, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata all 0.
  - Aborts any in-flight transaction; a late mem_ack is ignored.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - op = mem_read | mem_write; both high means store.
  - Illegal funct3 for loads: 011, 110, 111. For stores: anything other than 000, 001, 010.
  - Misaligned: half-word with addr[0]=1, or word with addr[1:0]!=0.
  - If op and (illegal or misaligned): fault=1 next cycle, stay IDLE, no mem_req, stall=0.
  - If op and legal: latch we, funct3, addr[1:0], mem_addr, wstrb and wdata; go to REQ.
- REQ:
  - mem_req=1; mem_* outputs held stable from the latched values.
  - Core inputs are ignored while in REQ.
  - On mem_ack: capture the extended mem_rdata into load_data; go to DONE.
- DONE:
  - done=1 for exactly one cycle, stall=0, then unconditionally IDLE.
  - The core advances at the end of DONE, so there is no re-trigger.
- Stall (combinational) = (IDLE & op & legal & aligned) | REQ.
- Latency: min 3 cycles from op to done (IDLE, REQ with same-cycle ack, DONE); each wait cycle on ack adds 1.
- mem_ack outside REQ: ignored.
- Store strobes/data:
  - SB: wstrb = 0001 << addr[1:0]; wdata = byte replicated x4.
  - SH: wstrb = 0011 << addr[1:0]; wdata = half replicated x2.
  - SW: wstrb = 1111; wdata = store_data.
- Load extract:
  - Select the lane by addr[1:0].
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
- load_data: holds its last value outside DONE; updated only on ack of a load. A store leaves it unchanged.

Decomposition:
- Shared package:
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - LSU state enum {IDLE, REQ, DONE}.
- One combinational sub-module, lsu_load_extend:
  - Inputs: rdata, offset[1:0], funct3.
  - Output: extended 32-bit word.
  - Reusable by a future cache path.

Test Plan:
- LW addr=0x100, ack same cycle as req, rdata=0xDEADBEEF:
  - mem_addr=0x100, mem_we=0; done after 3 cycles; load_data=0xDEADBEEF; stall high exactly 2 cycles.
- LB addr=0x203, rdata=0x80FF1234:
  - load_data=0xFFFFFF80.
  - LBU same stimulus → 0x00000080.
  - LHU addr=0x202 → 0x000080FF.
- SH addr=0x102, store_data=0x1234BEEF:
  - mem_addr=0x100, mem_we=1, wstrb=1100, wdata=0xBEEFBEEF.
  - load_data unchanged from its prior value.
- LW addr=0x1001, then SH addr=0x0003, then load funct3=011:
  - Each gives one fault pulse, mem_req never asserted, stall low.
- SW addr=0x40, ack delayed 5 cycles; addr/store_data changed to garbage during wait:
  - mem_* outputs stable; stall held 6 cycles; single done pulse.
- LW in REQ, rst_n=0 for one edge, then a stale mem_ack:
  - IDLE, mem_req=0, all outputs 0.
  - Stale ack produces no done.
